// File: rtl/mul_seq.sv
// Multi-cycle RV64M multiply sequencer: builds 64x64 products from one external 32x32 unsigned multiplier.
// Optional macro MUL_SKIP_HH_EN drops the aH*bH pass for MUL, which cannot reach bits [63:0].
module mul_seq #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [63:0]      in_src1,
  input  logic [63:0]      in_src2,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic [31:0]      mul_a,
  output logic [31:0]      mul_b,
  input  logic [63:0]      mul_p
);

  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_MULW   = 3'b100;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t             state, state_nxt;
  logic [1:0]         cnt;
  logic [127:0]       acc;
  logic [63:0]        a_mag, b_mag;
  logic               neg;
  logic [2:0]         op_q;
  logic [TAG_W-1:0]   tag_q;

  logic               accept;
  logic               a_sgn, b_sgn, is_w, is_hi, last_pass;
  logic signed [63:0] src1_s, src2_s;
  logic [127:0]       term;

  // Magnitude of a possibly signed operand; -2^63 wraps to 0x8000_0000_0000_0000.
  function automatic logic [63:0] mag(input logic signed [63:0] v, input logic sgn);
    logic signed [63:0] r;
    r = (sgn && (v < 0)) ? -v : v;
    return r;
  endfunction

  // Sign correction of the 128-bit accumulator followed by per-op result selection.
  function automatic logic [63:0] fix_sel(input logic [127:0] a, input logic n, input logic [2:0] op);
    logic [127:0] v;
    v = n ? (~a + 128'd1) : a;
    if (op == OP_MULW)
      return {{32{v[31]}}, v[31:0]};
    else if (op == OP_MULH || op == OP_MULHSU || op == OP_MULHU)
      return v[127:64];
    else
      return v[63:0];
  endfunction

  assign src1_s = in_src1;
  assign src2_s = in_src2;
  assign a_sgn  = (in_op == OP_MULH) || (in_op == OP_MULHSU);
  assign b_sgn  = (in_op == OP_MULH);
  assign accept = in_valid && in_ready && !flush;

  assign is_w  = (op_q == OP_MULW);
  assign is_hi = (op_q == OP_MULH) || (op_q == OP_MULHSU) || (op_q == OP_MULHU);

`ifdef MUL_SKIP_HH_EN
  assign last_pass = is_w ? (cnt == 2'd0) : (!is_hi ? (cnt == 2'd2) : (cnt == 2'd3));
`else
  assign last_pass = is_w ? (cnt == 2'd0) : (cnt == 2'd3);
`endif

  always_comb begin
    term = '0;
    case (cnt)
      2'd0:    term = {64'd0, mul_p};
      2'd1,
      2'd2:    term = {32'd0, mul_p, 32'd0};
      default: term = {mul_p, 64'd0};
    endcase
  end

  always_comb begin
    state_nxt = state;
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    mul_a     = '0;
    mul_b     = '0;
    if (state == CALC) begin
      // cnt[1] selects the high half of a, cnt[0] the high half of b.
      mul_a = cnt[1] ? a_mag[63:32] : a_mag[31:0];
      mul_b = cnt[0] ? b_mag[63:32] : b_mag[31:0];
    end
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state_nxt = CALC;
        CALC:    if (last_pass) state_nxt = FIX;
        FIX:     state_nxt = DONE;
        default: if (out_ready) state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      acc        <= '0;
      a_mag      <= '0;
      b_mag      <= '0;
      neg        <= 1'b0;
      op_q       <= '0;
      tag_q      <= '0;
      out_result <= '0;
      out_tag    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        // accept: operand prep
        IDLE: begin
          if (accept) begin
            cnt   <= '0;
            acc   <= '0;
            op_q  <= in_op;
            tag_q <= in_tag;
            if (in_op == OP_MULW) begin
              a_mag <= {32'd0, in_src1[31:0]};
              b_mag <= {32'd0, in_src2[31:0]};
              neg   <= 1'b0;
            end else begin
              a_mag <= mag(src1_s, a_sgn);
              b_mag <= mag(src2_s, b_sgn);
              neg   <= (a_sgn & in_src1[63]) ^ (b_sgn & in_src2[63]);
            end
          end
        end
        // one 32x32 partial product per cycle
        CALC: begin
          acc <= acc + term;
          cnt <= cnt + 2'd1;
        end
        // sign fix and result selection
        FIX: begin
          out_result <= fix_sel(acc, neg, op_q);
          out_tag    <= tag_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mul_seq.md
Name: mul_seq

Overview:
- Multi-cycle RV64M multiply sequencer for the NPC execute stage.
- Builds 64x64 products (MUL, MULH, MULHSU, MULHU, MULW) from one shared combinational 32x32 unsigned multiplier, issuing one 32x32 pass per cycle.
- Does sign correction, result selection and valid/ready handshakes toward the pipeline.
- The multiplier instance sits outside this block; it is driven through the mul_a/mul_b/mul_p ports.

Parameters:
- TAG_W, 5, width of the opaque tag (destination register index) passed from request to response.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  request valid
- in_ready  out  1  block can accept a request
- in_op  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 MULW; 101-111 treated as MUL
- in_src1  in  64  operand a (rs1)
- in_src2  in  64  operand b (rs2)
- in_tag  in  TAG_W  request tag
- flush  in  1  kill the in-flight operation
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_result  out  64  selected result
- out_tag  out  TAG_W  tag of the result
- mul_a  out  32  multiplier operand a
- mul_b  out  32  multiplier operand b
- mul_p  in  64  multiplier product, combinational, same cycle

Behaviour:
- Reset (async, any state): state=IDLE, out_valid=0, out_result=0, out_tag=0, accumulator=0, pass counter=0. mul_a and mul_b are 0 outside CALC.
- States:
  - IDLE: in_ready=1. in_valid&in_ready accepts the request (cycle T). Then state->CALC, counter=0, acc=0, and the op and tag are latched.
  - CALC: in_ready=0. One pass per cycle; acc += mul_p << shift.
  - FIX: one cycle. Sign correction and result selection; the result is written into out_result.
  - DONE: out_valid=1. On out_valid&out_ready go to IDLE.
- Operand prep at accept:
  - Signedness: MULH treats a and b as signed. MULHSU treats a as signed and b as unsigned. MUL, MULHU and MULW are unsigned.
  - neg = (a signed & a[63]) ^ (b signed & b[63]).
  - Stored operands are |a| and |b| as 64-bit unsigned. |-2^63| = 0x8000_0000_0000_0000 fits.
  - MULW uses a[31:0] and b[31:0] unsigned, with neg=0.
- Pass schedule (k = counter):
  - k0: aL*bL, shift 0.
  - k1: aL*bH, shift 32.
  - k2: aH*bL, shift 32.
  - k3: aH*bH, shift 64.
  - acc is 128-bit; all additions are mod 2^128.
  - MULW runs k0 only, so N=1. All other ops run k0..k3, so N=4.
- Timing:
  - CALC occupies T+1..T+N, FIX is T+N+1, out_valid first high at T+N+2.
  - Latency is 6 cycles for 64-bit ops and 3 for MULW.
  - Back-to-back: next accept no earlier than the cycle after the out handshake.
- FIX selection:
  - If neg, acc = ~acc + 1.
  - MUL returns acc[63:0].
  - MULH, MULHSU and MULHU return acc[127:64].
  - MULW returns the sign-extension of acc[31:0] to 64 bits.
- DONE hold: out_result and out_tag stay stable while out_valid=1 and out_ready=0, for any number of cycles.
- Flush:
  - In any state, the next state is IDLE and out_valid=0 from the next cycle.
  - A flush in DONE in the same cycle as out_ready: the flush wins and no transfer is counted.
  - Flush together with in_valid in IDLE: the request is not accepted.
- Unused ops: 101-111 execute exactly as MUL.

Optional Feature:
- MUL_SKIP_HH_EN defined:
  - For MUL (and 101-111), the k3 pass is skipped (N=3), because aH*bH<<64 cannot affect bits [63:0].
  - MUL latency becomes 5. Other ops are unchanged.
- Not defined: all 64-bit ops run 4 passes (latency 6).

Test Plan:
- MULHU src1=src2=0xFFFF_FFFF_FFFF_FFFF, out_ready=1 -> out_result=0xFFFF_FFFF_FFFF_FFFE, out_valid first high at T+6, in_ready=0 from T+1 until the handshake.
- MULH with src1=src2=0x8000_0000_0000_0000 -> 0x4000_0000_0000_0000. MULH with src1=src2=-1 -> 0. MUL with src1=src2=-1 -> 0x0000_0000_0000_0001.
- MULHSU src1=0xFFFF_FFFF_FFFF_FFFF (-1), src2=2 -> 0xFFFF_FFFF_FFFF_FFFF. MULW src1=0x7FFF_FFFF, src2=2 -> 0xFFFF_FFFF_FFFF_FFFE at T+3, out_tag=in_tag.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> out_result and out_tag unchanged, in_ready=0. out_ready=1 -> IDLE next cycle, and a new request is accepted that cycle.
- Flush at T+2 of a MULHU -> out_valid never rises, in_ready=1 at T+3. Async rst pulse mid-CALC -> all outputs are at their reset values immediately.
- MUL src1=0x1_0000_0001, src2=0x1_0000_0001 -> 0x0000_0002_0000_0001 at T+5 with MUL_SKIP_HH_EN, T+6 without.
